// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one clocked alu between two requesters
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_o,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  state_t     state, state_nxt;
  logic       prio;
  logic [3:0] cnt;
  logic       win;
  logic       take;
  logic       rsp_done;

  // winner is recomputed every cycle; only meaningful while idle
  assign win      = (req0_valid && req1_valid) ? prio : req1_valid;
  assign take     = req0_ready || req1_ready;
  assign rsp_done = grant_id ? rsp1_ready : rsp0_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !win;
          req1_ready = req1_valid && win;
        end
        if (req0_valid || req1_valid) state_nxt = WAIT;
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio       <= 1'b0;
      cnt        <= 4'd0;
      grant_id   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          alu_a    <= win ? req1_a  : req0_a;
          alu_b    <= win ? req1_b  : req0_b;
          alu_op   <= win ? req1_op : req0_op;
          grant_id <= win;
          cnt      <= LAT4;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (grant_id) begin
              rsp1_data  <= alu_o;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_data  <= alu_o;
              rsp0_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (rsp_done) begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          prio       <= ~grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized bench for alu_arbiter against a transaction model
module tb_alu_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0]  req0_op = 0, req1_op = 0, alu_op;
  logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_o;

  logic        q_req0_valid = 0, q_rsp0_ready = 1;
  logic        q_req0_ready, q_req1_ready, q_rsp0_valid, q_rsp1_valid, q_busy, q_grant_id;
  logic [31:0] q_req0_a = 0, q_rsp0_data, q_rsp1_data, q_alu_a, q_alu_b, q_alu_o;
  logic [2:0]  q_req0_op = 0, q_alu_op;
  logic [31:0] qp [4];

  int checks = 0, errors = 0;

  // transaction-level reference state
  logic        out = 0, owner = 0, prio_m = 0;
  int          n = 0, t_issue = 0, last_owner = -1;
  logic [31:0] exp_d = 0, last_data = 0, hold_d;
  int          order[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] aluf(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return ~a;
      default: return b;
    endcase
  endfunction

  always @(posedge clk) alu_o <= aluf(alu_a, alu_b, alu_op);
  always @(posedge clk) begin
    qp[0] <= aluf(q_alu_a, q_alu_b, q_alu_op);
    for (int i = 1; i < 4; i++) qp[i] <= qp[i-1];
  end
  assign q_alu_o = qp[3];

  alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o),
    .busy(busy), .grant_id(grant_id)
  );

  alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(q_req0_valid), .req0_ready(q_req0_ready), .req0_a(q_req0_a), .req0_b(32'h0), .req0_op(q_req0_op),
    .req1_valid(1'b0), .req1_ready(q_req1_ready), .req1_a(32'h0), .req1_b(32'h0), .req1_op(3'h0),
    .rsp0_valid(q_rsp0_valid), .rsp0_ready(q_rsp0_ready), .rsp0_data(q_rsp0_data),
    .rsp1_valid(q_rsp1_valid), .rsp1_ready(1'b1), .rsp1_data(q_rsp1_data),
    .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_op(q_alu_op), .alu_o(q_alu_o),
    .busy(q_busy), .grant_id(q_grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_rsp0_data"}, rsp0_data, 0);
    chk({tag, "_rsp1_data"}, rsp1_data, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  task automatic model_reset();
    out = 0;
    prio_m = 0;
  endtask

  // one clock edge: check outputs on the falling edge, predict what the next rising edge does
  task automatic cyc();
    logic e0, e1, rv;
    @(negedge clk);
    if (!out) begin
      e0 = req0_valid && (!req1_valid || prio_m == 1'b0);
      e1 = req1_valid && (!req0_valid || prio_m == 1'b1);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("busy_idle", busy, 0);
      chk("rsp0_valid_idle", rsp0_valid, 0);
      chk("rsp1_valid_idle", rsp1_valid, 0);
      if (e0 || e1) begin
        out = 1;
        owner = e1;
        t_issue = n;
        exp_d = e1 ? aluf(req1_a, req1_b, req1_op) : aluf(req0_a, req0_b, req0_op);
      end
    end else begin
      rv = (n >= t_issue + LAT + 2);
      chk("req0_ready_busy", req0_ready, 0);
      chk("req1_ready_busy", req1_ready, 0);
      chk("busy", busy, 1);
      chk("grant_id", grant_id, owner);
      chk("rsp_valid_owner", owner ? rsp1_valid : rsp0_valid, rv);
      chk("rsp_valid_other", owner ? rsp0_valid : rsp1_valid, 0);
      if (rv) begin
        chk("rsp_data", owner ? rsp1_data : rsp0_data, exp_d);
        if (owner ? rsp1_ready : rsp0_ready) begin
          out = 0;
          prio_m = ~owner;
          last_owner = owner;
          last_data = owner ? rsp1_data : rsp0_data;
          order.push_back(int'(owner));
        end
      end
    end
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1 chk_zero("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // single NOT
    req0_valid = 1; req0_a = 32'hCD0AD074; req0_b = $urandom; req0_op = 3'b110;
    #1 chk("single_ready_first", req0_ready, 1);
    cyc();
    req0_valid = 0;
    cyc();
    chk("single_t1_valid", rsp0_valid, 0);
    cyc();
    chk("single_t2_valid", rsp0_valid, 1);
    chk("single_t2_data", rsp0_data, 32'h32F52F8B);
    cyc();
    chk("single_t3_valid", rsp0_valid, 0);
    chk("single_rsp1", rsp1_valid, 0);

    // simultaneous requests, then continuous alternation
    do_reset();
    req0_valid = 1; req0_a = 32'h34EB5103; req0_op = 3'b110;
    req1_valid = 1; req1_a = 32'h55174CA3; req1_op = 3'b110;
    cyc();
    req0_valid = 0;
    repeat (3) cyc();
    chk("simul_first_owner", last_owner, 0);
    chk("simul_first_data", last_data, 32'hCB14AEFC);
    cyc();
    req1_valid = 0;
    repeat (3) cyc();
    chk("simul_second_owner", last_owner, 1);
    chk("simul_second_data", last_data, 32'hAAE8B35C);
    order.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 16; i++) begin
      req0_a = $urandom; req1_a = $urandom; req0_b = $urandom; req1_b = $urandom;
      cyc();
    end
    req0_valid = 0; req1_valid = 0;
    chk("alt_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("alt_order", order[i], i % 2);

    // response backpressure on requester 1
    req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = 3'd0; rsp1_ready = 0;
    hold_d = aluf(req1_a, req1_b, req1_op);
    cyc();
    req1_valid = 0; req0_valid = 1;
    for (int i = 0; i < 8 && !rsp1_valid; i++) cyc();
    chk("bp_wait", rsp1_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", rsp1_valid, 1);
      chk("bp_data", rsp1_data, hold_d);
      chk("bp_req0_ready", req0_ready, 0);
    end
    rsp1_ready = 1;
    cyc();
    chk("bp_release", rsp1_valid, 0);
    cyc();
    req0_valid = 0;
    repeat (3) cyc();

    // latency parameter on the second instance
    q_req0_valid = 1; q_req0_a = 32'hCD0AD074; q_req0_op = 3'b110;
    cyc();
    q_req0_valid = 0;
    chk("lat4_alu_a", q_alu_a, 32'hCD0AD074);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("lat4_no_valid", q_rsp0_valid, 0);
      chk("lat4_alu_hold", q_alu_a, 32'hCD0AD074);
    end
    cyc();
    chk("lat4_valid", q_rsp0_valid, 1);
    chk("lat4_data", q_rsp0_data, 32'h32F52F8B);
    cyc();
    chk("lat4_done", q_rsp0_valid, 0);

    // asynchronous reset while waiting on the alu
    req0_valid = 1; req0_a = $urandom; req0_op = 3'd4;
    cyc();
    req0_valid = 0; req1_valid = 1;
    #1 rst = 1'b1;
    model_reset();
    #1 chk_zero("midrst");
    #1 rst = 1'b0;
    req1_valid = 0;
    repeat (4) cyc();
    req1_valid = 1; req1_a = $urandom; req1_op = 3'd1;
    cyc();
    req1_valid = 0;
    repeat (3) cyc();
    chk("midrst_req1_served", last_owner, 1);
    do_reset();
    req0_valid = 1; req1_valid = 1;
    cyc();
    chk("midrst_prio0", grant_id, 0);
    req0_valid = 0; req1_valid = 0;
    repeat (3) cyc();

    // valid pulse on requester 1 while requester 0 is in flight
    req0_valid = 1; req0_a = $urandom;
    cyc();
    req0_valid = 0; req1_valid = 1;
    cyc();
    req1_valid = 0;
    chk("withdraw_grant", grant_id, 0);
    cyc();
    chk("withdraw_grant2", grant_id, 0);
    cyc();
    cyc();
    chk("withdraw_idle", busy, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
      req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one clocked `alu` instance between two requesters. It accepts an operation (A, B, OPERATIONCODE) from one requester at a time and drives the ALU operand/opcode inputs. It waits a fixed ALU latency, captures `O`, and returns the result to the requester that issued the operation. It sits between the operand-producing logic and the ALU, and is the only block that drives the ALU inputs.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width.
- `OPW`, 3: opcode width, same as ALU `OPERATIONCODE`.
- `ALU_LAT`, 1: clock edges from the ALU sampling its inputs to `O` being valid. Legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1: requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1: operation accepted on this edge when high together with valid.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH: operands.
- `req0_op` / `req1_op`  in  OPW: opcode.
- `rsp0_valid` / `rsp1_valid`  out  1: result available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1: requester consumes result.
- `rsp0_data` / `rsp1_data`  out  WIDTH: result.
- `alu_a`, `alu_b`  out  WIDTH: drive ALU `A`, `B`.
- `alu_op`  out  OPW: drives ALU `OPERATIONCODE`.
- `alu_o`  in  WIDTH: from ALU `O`.
- `busy`  out  1: high in any state other than IDLE.
- `grant_id`  out  1: index of the requester currently owning the ALU (last granted when idle).

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- **IDLE:**
  - The grant is computed combinationally from the valids and the priority pointer `prio`.
  - If only one requester is valid, it wins.
  - If both are valid, requester `prio` wins.
  - Only the winner's `reqN_ready` is high. Both readys are low if neither is valid.
  - On the handshake edge:
    - `alu_a`, `alu_b`, `alu_op` are registered from the winner.
    - `grant_id` is set to the winner.
    - The wait counter is loaded with `ALU_LAT`.
    - The FSM goes to WAIT.
- **WAIT:**
  - Both readys are low. `alu_*` are held stable.
  - The counter decrements on each edge.
  - On the edge where the counter is 0:
    - `rspN_data` of the granted requester is loaded from `alu_o`.
    - `rspN_valid` is set.
    - The FSM goes to RESP.
- **RESP:**
  - `rspN_valid` and `rspN_data` are held until `rspN_ready` is high on an edge.
  - On that edge:
    - `rspN_valid` is cleared.
    - `prio` is set to the other requester.
    - The FSM goes to IDLE.
  - The `rsp_ready` of the non-granted requester is ignored.
- `rspN_data` keeps its last value after consumption and changes only on capture.
- Opcodes pass through unmodified; the arbiter does not decode them.
- Only one operation is in flight at a time; there is no queueing.
- A requester's valid deasserting in IDLE before the handshake is legal. The grant is recomputed every cycle.
- **Reset (asynchronous, any state, including mid-operation):**
  - State goes to IDLE and `prio` to 0.
  - All outputs go to 0: `req*_ready` (combinational, 0 while `rst` is high), `rsp*_valid`, `rsp*_data`, `alu_a`, `alu_b`, `alu_op`, `busy`, `grant_id`.
  - The in-flight operation is dropped and no response is emitted.

## Timing
- Request handshake at edge T. `alu_*` are updated after T. The ALU samples them at T+1.
- The result is captured at edge T+1+ALU_LAT. `rspN_valid` is high after that edge; with `ALU_LAT`=1, valid is high after T+2.
- If `rspN_ready` is already high, the response handshake occurs at T+2+ALU_LAT. The FSM is in IDLE after that edge.
- The next request handshake can occur at that same IDLE cycle's edge, T+3+ALU_LAT.
- The minimum issue-to-issue interval is ALU_LAT+3 cycles.
- Backpressure on `rsp_ready` extends RESP indefinitely. The other requester stalls and its ready stays low.
- `busy` is high from after edge T until after the response handshake edge.

## Test plan
- **Single NOT:** reset, then `req0_valid`=1, `req0_a`=32'hCD0AD074, `req0_op`=3'b110, `rsp0_ready`=1.
  - `req0_ready` high in the first IDLE cycle.
  - `rsp0_valid` rises after T+2 with `rsp0_data`=32'h32F52F8B, high one cycle.
  - `rsp1_valid` stays 0.
- **Simultaneous requests:** after reset, both valid; req0 `a`=32'h34EB5103, req1 `a`=32'h55174CA3, both NOT.
  - Req0 is granted first with result 32'hCB14AEFC.
  - Then req1 is granted with result 32'hAAE8B35C.
  - Continuous dual requests alternate 0,1,0,1.
- **Response backpressure:** `rsp1_ready`=0 for 5 cycles after `rsp1_valid` rises.
  - `rsp1_valid` and `rsp1_data` stay constant.
  - `req0_ready` stays 0 throughout.
  - Completion follows 1 cycle after `rsp1_ready` rises.
- **Latency parameter:** repeat the single-NOT case with a behavioral ALU model and `ALU_LAT`=4.
  - Capture occurs at T+5.
  - `alu_a` stays stable from after T until capture.
- **Reset mid-operation:** pulse `rst` asynchronously (between edges) while in WAIT.
  - All outputs read 0 immediately.
  - No `rsp_valid` pulse follows.
  - Next request from req1 alone is served, and with both valid req0 is served first (`prio`=0).
- **Valid withdrawn:** `req1_valid` pulses 1 cycle while FSM is in WAIT for req0.
  - The pulse is ignored, with no extra grant.
  - `grant_id` stays 0 until the RESP handshake.
